// File: rtl/cfg_clk_div_pkg.sv
// ============================================================================
// Module : cfg_clk_div_pkg
// Brief  : Shared constants and types for the configurable clock divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfg_clk_div_pkg;

  localparam int NUM_CH   = 4;
  localparam int IDX_CVA6 = 0;
  localparam int IDX_SOC  = 1;
  localparam int IDX_PER  = 2;
  localparam int IDX_CLU  = 3;

  localparam int EN_BIT   = 31;
  localparam int DIV_W    = 8;

  localparam int DIV_RST_CVA6_DEF = 1;
  localparam int DIV_RST_SOC_DEF  = 2;
  localparam int DIV_RST_PER_DEF  = 4;
  localparam int DIV_RST_CLU_DEF  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/cfg_clk_div_gen_clk_div_toggle.sv
// ============================================================================
// Module : clk_div_toggle
// Brief  : One divider channel: counter, shadowed divider reload, toggle flop.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_toggle #(
  parameter int DIV_WIDTH = 8,
  parameter int RST_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 test_mode,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 clk_out
);

  localparam logic [DIV_WIDTH-1:0] C_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] C_E_RST = (RST_DIV == 0) ? C_ONE : DIV_WIDTH'(RST_DIV);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_e_act;
  logic                 r_out;
  logic [DIV_WIDTH-1:0] w_e_new;
  logic                 w_wrap;

  assign w_e_new = (test_mode || (div == '0)) ? C_ONE : div;
  assign w_wrap  = (r_cnt == (r_e_act - C_ONE));

  // The active divider only changes at a toggle point so no half period is cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_e_act <= C_E_RST;
      r_out   <= 1'b0;
    end else if (!en) begin
      r_cnt   <= '0;
      r_e_act <= w_e_new;
      r_out   <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_e_act <= w_e_new;
      r_out   <= ~r_out;
    end else begin
      r_cnt   <= r_cnt + C_ONE;
    end
  end

  assign clk_out = r_out;

endmodule

`default_nettype wire

// File: rtl/cfg_clk_div_gen.sv
// ============================================================================
// Module : cfg_clk_div_gen
// Brief  : Four-output programmable even clock divider with 4-phase config bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_clk_div_gen
  import cfg_clk_div_pkg::*;
#(
  parameter int ADDR_WIDTH   = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int DIV_WIDTH    = DIV_W,
  parameter int DIV_RST_CVA6 = DIV_RST_CVA6_DEF,
  parameter int DIV_RST_SOC  = DIV_RST_SOC_DEF,
  parameter int DIV_RST_PER  = DIV_RST_PER_DEF,
  parameter int DIV_RST_CLU  = DIV_RST_CLU_DEF
) (
  input  logic                  ref_clk_i,
  input  logic                  rst_i,
  input  logic                  test_mode_i,
  input  logic                  cfg_req_i,
  output logic                  cfg_ack_o,
  input  logic [ADDR_WIDTH-1:0] cfg_add_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  output logic [DATA_WIDTH-1:0] cfg_r_data_o,
  input  logic                  cfg_wrn_i,
  output logic                  cva6_clk_o,
  output logic                  soc_clk_o,
  output logic                  per_clk_o,
  output logic                  cluster_clk_o
);

  bus_state_t            r_state;
  bus_state_t            w_state_nxt;
  logic                  w_access;

  logic [DIV_WIDTH-1:0]  r_div [NUM_CH];
  logic [NUM_CH-1:0]     r_en;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [NUM_CH-1:0]     w_clk;
  logic                  w_unused;

  assign w_unused = ^cfg_data_i[EN_BIT-1:DIV_WIDTH];

  always_ff @(posedge ref_clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // One access per request pulse: execute only on the IDLE->ACK transition.
  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: if (cfg_req_i) begin
        w_access    = 1'b1;
        w_state_nxt = ST_ACK;
      end
      ST_ACK:  if (!cfg_req_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd                  = '0;
    w_rd[DIV_WIDTH-1:0]   = r_div[cfg_add_i];
    w_rd[EN_BIT]          = r_en[cfg_add_i];
  end

  always_ff @(posedge ref_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div[IDX_CVA6] <= DIV_WIDTH'(DIV_RST_CVA6);
      r_div[IDX_SOC]  <= DIV_WIDTH'(DIV_RST_SOC);
      r_div[IDX_PER]  <= DIV_WIDTH'(DIV_RST_PER);
      r_div[IDX_CLU]  <= DIV_WIDTH'(DIV_RST_CLU);
      r_en            <= '1;
      r_rdata         <= '0;
    end else if (w_access) begin
      if (!cfg_wrn_i) begin
        r_div[cfg_add_i] <= cfg_data_i[DIV_WIDTH-1:0];
        r_en[cfg_add_i]  <= cfg_data_i[EN_BIT];
      end else begin
        r_rdata <= w_rd;
      end
    end
  end

  assign cfg_ack_o    = (r_state == ST_ACK);
  assign cfg_r_data_o = r_rdata;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int C_RST = (i == IDX_CVA6) ? DIV_RST_CVA6 :
                             (i == IDX_SOC)  ? DIV_RST_SOC  :
                             (i == IDX_PER)  ? DIV_RST_PER  : DIV_RST_CLU;
      clk_div_toggle #(
        .DIV_WIDTH (DIV_WIDTH),
        .RST_DIV   (C_RST)
      ) u_div (
        .clk       (ref_clk_i),
        .rst       (rst_i),
        .en        (r_en[i]),
        .test_mode (test_mode_i),
        .div       (r_div[i]),
        .clk_out   (w_clk[i])
      );
    end
  endgenerate

  assign cva6_clk_o    = w_clk[IDX_CVA6];
  assign soc_clk_o     = w_clk[IDX_SOC];
  assign per_clk_o     = w_clk[IDX_PER];
  assign cluster_clk_o = w_clk[IDX_CLU];

endmodule

`default_nettype wire

// File: tb/tb_cfg_clk_div_gen.sv
// ============================================================================
// Module : tb_cfg_clk_div_gen
// Brief  : Directed self-checking bench for the configurable clock divider.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfg_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        test_mode;
  logic        req;
  logic        ack;
  logic [1:0]  add;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wrn;
  logic        cva6, soc, per, clu;
  logic [3:0]  clks;

  int checks = 0;
  int errors = 0;

  assign clks = {clu, per, soc, cva6};

  always #5 clk = ~clk;

  cfg_clk_div_gen dut (
    .ref_clk_i     (clk),
    .rst_i         (rst),
    .test_mode_i   (test_mode),
    .cfg_req_i     (req),
    .cfg_ack_o     (ack),
    .cfg_add_i     (add),
    .cfg_data_i    (wdata),
    .cfg_r_data_o  (rdata),
    .cfg_wrn_i     (wrn),
    .cva6_clk_o    (cva6),
    .soc_clk_o     (soc),
    .per_clk_o     (per),
    .cluster_clk_o (clu)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Period and high time (ref cycles) between the next two rising edges; -1 on timeout.
  task automatic measure(input int ch, output int period, output int high);
    int t0, t1, tf;
    logic prev, cur;
    t0 = -1; t1 = -1; tf = -1;
    @(negedge clk);
    prev = clks[ch];
    for (int n = 0; n < 200 && t1 < 0; n++) begin
      @(negedge clk);
      cur = clks[ch];
      if (!prev && cur) begin
        if (t0 < 0) t0 = n;
        else        t1 = n;
      end
      if (prev && !cur && t0 >= 0 && tf < 0) tf = n;
      prev = cur;
    end
    period = (t1 < 0) ? -1 : t1 - t0;
    high   = (tf < 0) ? -1 : tf - t0;
  endtask

  task automatic access(input logic rw, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output logic ack_after);
    @(negedge clk);
    req = 1'b1; wrn = rw; add = a; wdata = d;
    lat = -1; rd = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ack) begin
        lat = n;
        rd  = rdata;
        break;
      end
    end
    req = 1'b0;
    @(negedge clk);
    ack_after = ack;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int p, h, lat, minrun, run, ones;
    logic [31:0] rd;
    logic ackd, prev, seen_edge;

    rst = 1'b1; test_mode = 1'b0; req = 1'b0; add = '0; wdata = '0; wrn = 1'b1;
    wait_cycles(4);
    chk("rst_clks", {28'd0, clks}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    measure(0, p, h); chk("cva6_period", p, 2); chk("cva6_high", h, 1);
    measure(1, p, h); chk("soc_period", p, 4);  chk("soc_high", h, 2);
    measure(2, p, h); chk("per_period", p, 8);  chk("per_high", h, 4);
    measure(3, p, h); chk("clu_period", p, 4);  chk("clu_high", h, 2);

    access(1'b1, 2'd1, 32'd0, rd, lat, ackd);
    chk("rd_soc_lat", lat, 1);
    chk("rd_soc_data", rd, 32'h8000_0002);
    chk("rd_soc_ackdrop", {31'd0, ackd}, 32'd0);

    // Divider change on per: every half period across the switch is at least 3 cycles.
    access(1'b0, 2'd2, 32'h8000_0003, rd, lat, ackd);
    chk("wr_per_lat", lat, 1);
    chk("wr_per_ackdrop", {31'd0, ackd}, 32'd0);
    minrun = 1000; run = 0; seen_edge = 1'b0; prev = per;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (per != prev) begin
        if (seen_edge && run < minrun) minrun = run;
        seen_edge = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev = per;
    end
    chk("per_no_runt", (minrun >= 3 && minrun != 1000) ? 1 : 0, 1);
    measure(2, p, h); chk("per6_period", p, 6); chk("per6_high", h, 3);
    access(1'b1, 2'd2, 32'd0, rd, lat, ackd);
    chk("rd_per_new", rd, 32'h8000_0003);

    access(1'b0, 2'd0, 32'hFFFF_FF01, rd, lat, ackd);
    access(1'b1, 2'd0, 32'd0, rd, lat, ackd);
    chk("rd_cva6_rsvd", rd, 32'h8000_0001);

    access(1'b0, 2'd3, 32'h0000_0002, rd, lat, ackd);
    wait_cycles(2);
    ones = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (clu) ones++;
    end
    chk("clu_disabled", ones, 0);
    access(1'b1, 2'd3, 32'd0, rd, lat, ackd);
    chk("rd_clu_dis", rd, 32'h0000_0002);
    access(1'b0, 2'd3, 32'h8000_0002, rd, lat, ackd);
    measure(3, p, h); chk("clu_restart_period", p, 4); chk("clu_restart_high", h, 2);

    test_mode = 1'b1;
    wait_cycles(20);
    measure(0, p, h); chk("tm_cva6", p, 2);
    measure(1, p, h); chk("tm_soc", p, 2);
    measure(2, p, h); chk("tm_per", p, 2);
    measure(3, p, h); chk("tm_clu", p, 2);
    test_mode = 1'b0;
    wait_cycles(20);
    measure(2, p, h); chk("tm_off_per", p, 6);

    access(1'b0, 2'd1, 32'h8000_0000, rd, lat, ackd);
    wait_cycles(20);
    measure(1, p, h); chk("soc_div0_period", p, 2); chk("soc_div0_high", h, 1);
    access(1'b1, 2'd1, 32'd0, rd, lat, ackd);
    chk("rd_soc_div0", rd, 32'h8000_0000);

    // Reset mid-access, asserted away from any clock edge.
    @(negedge clk);
    req = 1'b1; wrn = 1'b1; add = 2'd2;
    @(negedge clk);
    chk("mid_ack_high", {31'd0, ack}, 32'd1);
    wait_cycles(3);
    #2 rst = 1'b1;
    #1;
    chk("async_ack", {31'd0, ack}, 32'd0);
    chk("async_clks", {28'd0, clks}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    access(1'b1, 2'd2, 32'd0, rd, lat, ackd);
    chk("rst_per_reg", rd, 32'h8000_0004);
    access(1'b1, 2'd1, 32'd0, rd, lat, ackd);
    chk("rst_soc_reg", rd, 32'h8000_0002);
    measure(2, p, h); chk("rst_per_period", p, 8);
    measure(1, p, h); chk("rst_soc_period", p, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
